// File: rtl/bist_lfsr_engine_pkg.sv
// Shared definitions for the BIST LFSR/MISR engine.
//   - fsm_e     : controller states IDLE / RUN / DONE
//   - MODE_*    : run-mode encodings captured on an accepted start
//   - DEF_TAPS, DEF_SEED : default polynomial and seed for the 16-bit build
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  localparam logic MODE_GEN  = 1'b0;
  localparam logic MODE_MISR = 1'b1;

  localparam logic [15:0] DEF_TAPS = 16'h002D;
  localparam logic [15:0] DEF_SEED = 16'hFFFF;

endpackage

// File: rtl/bist_lfsr_engine_if.sv
// Control/data bundle between a BIST controller and the LFSR engine.
//   master : the controller (drives start/mode/num_patterns/seed/abort/din)
//   slave  : the engine (drives pattern/pattern_valid/busy/done/signature/lockup)
interface bist_lfsr_engine_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);

  logic             start;
  logic             mode;
  logic [CNT_W-1:0] num_patterns;
  logic             seed_load;
  logic [WIDTH-1:0] seed;
  logic             abort;
  logic [WIDTH-1:0] din;
  logic             din_valid;

  logic [WIDTH-1:0] pattern;
  logic             pattern_valid;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] signature;
  logic             lockup;

  modport master (
    output start, mode, num_patterns, seed_load, seed, abort, din, din_valid,
    input  pattern, pattern_valid, busy, done, signature, lockup
  );

  modport slave (
    input  start, mode, num_patterns, seed_load, seed, abort, din, din_valid,
    output pattern, pattern_valid, busy, done, signature, lockup
  );

endinterface

// File: rtl/bist_lfsr_engine_lfsr_step.sv
// One step of a right-shifting Fibonacci LFSR, optionally folding in a
// response word to act as a MISR.
//   state      : current register value
//   din        : response word XORed in when din_en is high
//   din_en     : 1 = MISR step, 0 = plain LFSR step
//   next_state : {^(state & TAPS), state[WIDTH-1:1]} ^ (din_en ? din : 0)
module lfsr_step
  import bist_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS)
) (
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] din,
  input  logic             din_en,
  output logic [WIDTH-1:0] next_state
);

  logic fb;

  assign fb         = ^(state & TAPS);
  assign next_state = {fb, state[WIDTH-1:1]} ^ (din_en ? din : '0);

endmodule

// File: rtl/bist_lfsr_engine.sv
// BIST pattern generator / signature compactor.
// Runs a Fibonacci LFSR (GEN) or a MISR over din (MISR) for num_patterns
// steps under a start/busy/done handshake, with runtime seed load, abort
// and all-zero lockup recovery in GEN mode.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : slave side of bist_lfsr_engine_if (controls in, results out)
// Every output is a flop; nothing on the bus passes combinationally through.
module bist_lfsr_engine
  import bist_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0] SEED  = (WIDTH == 16) ? WIDTH'(DEF_SEED) : {WIDTH{1'b1}},
  parameter int               CNT_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  bist_lfsr_engine_if.slave bus
);

  fsm_e             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic             pattern_valid_q, pattern_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] signature_q, signature_d;
  logic             lockup_q, lockup_d;

  logic [WIDTH-1:0] state_step;
  logic [WIDTH-1:0] eff_state;
  logic [CNT_W-1:0] cnt_inc;
  logic             advance;

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .state      (state_q),
    .din        (bus.din),
    .din_en     (mode_q == MODE_MISR),
    .next_state (state_step)
  );

  // cnt_q stays below num_q while running, so the increment never wraps.
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    fsm_d           = fsm_q;
    state_d         = state_q;
    mode_d          = mode_q;
    num_d           = num_q;
    cnt_d           = cnt_q;
    pattern_d       = pattern_q;
    pattern_valid_d = 1'b0;
    busy_d          = 1'b0;
    done_d          = 1'b0;
    signature_d     = signature_q;
    lockup_d        = lockup_q;
    advance         = 1'b0;
    // A seed written alongside start is the value the run starts from.
    eff_state       = bus.seed_load ? bus.seed : state_q;

    unique case (fsm_q)
      IDLE: begin
        state_d = eff_state;
        if (bus.start) begin
          mode_d   = bus.mode;
          num_d    = bus.num_patterns;
          cnt_d    = '0;
          lockup_d = 1'b0;
          // An all-zero LFSR never leaves zero; restart it from SEED.
          if (bus.mode == MODE_GEN && eff_state == '0) begin
            state_d  = SEED;
            lockup_d = 1'b1;
          end
          if (bus.num_patterns == '0) begin
            fsm_d       = DONE;
            done_d      = 1'b1;
            signature_d = state_d;
          end else begin
            fsm_d  = RUN;
            busy_d = 1'b1;
            // The first pattern must already be on the output in cycle 1.
            if (bus.mode == MODE_GEN) begin
              pattern_valid_d = 1'b1;
              pattern_d       = state_d;
            end
          end
        end
      end

      RUN: begin
        // Abort freezes state and signature and suppresses done.
        if (bus.abort) begin
          fsm_d = IDLE;
        end else begin
          advance = (mode_q == MODE_GEN) || bus.din_valid;
          if (advance) begin
            state_d = state_step;
            cnt_d   = cnt_inc;
          end
          if (advance && cnt_inc == num_q) begin
            fsm_d       = DONE;
            done_d      = 1'b1;
            signature_d = state_step;
          end else begin
            busy_d = 1'b1;
            if (mode_q == MODE_GEN) begin
              pattern_valid_d = 1'b1;
              pattern_d       = state_step;
            end
          end
        end
      end

      // done and signature were registered on entry; just go home
      // (abort here has nothing left to cancel).
      DONE:    fsm_d = IDLE;

      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q           <= IDLE;
      state_q         <= SEED;
      mode_q          <= MODE_GEN;
      num_q           <= '0;
      cnt_q           <= '0;
      pattern_q       <= '0;
      pattern_valid_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      signature_q     <= '0;
      lockup_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge
      // values computed above, independent of statement order.
      fsm_q           <= fsm_d;
      state_q         <= state_d;
      mode_q          <= mode_d;
      num_q           <= num_d;
      cnt_q           <= cnt_d;
      pattern_q       <= pattern_d;
      pattern_valid_q <= pattern_valid_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      signature_q     <= signature_d;
      lockup_q        <= lockup_d;
    end
  end

  assign bus.pattern       = pattern_q;
  assign bus.pattern_valid = pattern_valid_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.signature     = signature_q;
  assign bus.lockup        = lockup_q;

endmodule

// File: tb/tb_bist_lfsr_engine.sv
// Directed bench for bist_lfsr_engine (WIDTH 16, TAPS 002D, SEED FFFF).
// Inputs change and outputs are sampled 1 ns after each rising edge;
// "cycle k" is the interval following edge k-1, edge 0 accepting start.
module tb_bist_lfsr_engine;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  bist_lfsr_engine_if #(.WIDTH(16), .CNT_W(16)) bus ();

  bist_lfsr_engine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.mode         = 1'b0;
    bus.num_patterns = '0;
    bus.seed_load    = 1'b0;
    bus.seed         = '0;
    bus.abort        = 1'b0;
    bus.din          = '0;
    bus.din_valid    = 1'b0;

    // ---- reset values
    #2;
    check("rst_pattern",   bus.pattern,       32'h0);
    check("rst_pvalid",    bus.pattern_valid, 32'h0);
    check("rst_busy",      bus.busy,          32'h0);
    check("rst_done",      bus.done,          32'h0);
    check("rst_signature", bus.signature,     32'h0);
    check("rst_lockup",    bus.lockup,        32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---- GEN, reset seed FFFF, N = 3
    bus.start = 1'b1; bus.mode = 1'b0; bus.num_patterns = 16'd3;
    tick();                               // cycle 1
    bus.start = 1'b0;
    check("gen3_c1_pattern", bus.pattern,       32'hFFFF);
    check("gen3_c1_pvalid",  bus.pattern_valid, 32'h1);
    check("gen3_c1_busy",    bus.busy,          32'h1);
    check("gen3_c1_done",    bus.done,          32'h0);
    tick();                               // cycle 2
    check("gen3_c2_pattern", bus.pattern,       32'h7FFF);
    tick();                               // cycle 3
    check("gen3_c3_pattern", bus.pattern,       32'h3FFF);
    check("gen3_c3_done",    bus.done,          32'h0);
    tick();                               // cycle 4
    check("gen3_c4_done",    bus.done,          32'h1);
    check("gen3_c4_pvalid",  bus.pattern_valid, 32'h0);
    check("gen3_c4_busy",    bus.busy,          32'h0);
    check("gen3_signature",  bus.signature,     32'h1FFF);
    tick();                               // cycle 5
    check("gen3_c5_done",    bus.done,          32'h0);
    check("gen3_sig_hold",   bus.signature,     32'h1FFF);

    // ---- lockup: load 0000, then GEN N = 1 recovers to SEED
    bus.seed_load = 1'b1; bus.seed = 16'h0000;
    tick();
    bus.seed_load = 1'b0;
    bus.start = 1'b1; bus.mode = 1'b0; bus.num_patterns = 16'd1;
    tick();                               // cycle 1
    bus.start = 1'b0;
    check("lock_c1_lockup",  bus.lockup,        32'h1);
    check("lock_c1_pattern", bus.pattern,       32'hFFFF);
    check("lock_c1_pvalid",  bus.pattern_valid, 32'h1);
    tick();                               // cycle 2
    check("lock_c2_done",    bus.done,          32'h1);
    check("lock_signature",  bus.signature,     32'h7FFF);
    check("lock_sticky",     bus.lockup,        32'h1);
    tick();

    // ---- N = 0 (also the next start, which clears lockup)
    bus.start = 1'b1; bus.mode = 1'b0; bus.num_patterns = 16'd0;
    tick();                               // cycle 1
    bus.start = 1'b0;
    check("n0_c1_done",    bus.done,          32'h1);
    check("n0_c1_pvalid",  bus.pattern_valid, 32'h0);
    check("n0_c1_busy",    bus.busy,          32'h0);
    check("n0_lockup_clr", bus.lockup,        32'h0);
    tick();                               // cycle 2
    check("n0_c2_done",    bus.done,          32'h0);
    check("n0_c2_pvalid",  bus.pattern_valid, 32'h0);

    // ---- seed_load together with start: run starts from the new seed
    bus.seed_load = 1'b1; bus.seed = 16'h1234;
    bus.start = 1'b1; bus.mode = 1'b0; bus.num_patterns = 16'd1;
    tick();
    bus.seed_load = 1'b0; bus.start = 1'b0;
    check("seedstart_pattern", bus.pattern, 32'h1234);
    tick();
    check("seedstart_done",    bus.done,    32'h1);
    tick();

    // ---- MISR from 0000, N = 2, beats 0001, gap, 0003.
    // Beat 1: fb(0000)=0 -> 0000 ^ 0001 = 0001.
    // Beat 2: fb(0001)=bit0=1 -> {1,000_0000_0000_000} = 8000, ^ 0003 = 8003.
    bus.seed_load = 1'b1; bus.seed = 16'h0000;
    tick();
    bus.seed_load = 1'b0;
    bus.start = 1'b1; bus.mode = 1'b1; bus.num_patterns = 16'd2;
    tick();                               // cycle 1
    bus.start = 1'b0;
    check("misr_c1_busy",   bus.busy,          32'h1);
    check("misr_c1_pvalid", bus.pattern_valid, 32'h0);
    check("misr_no_lockup", bus.lockup,        32'h0);
    bus.din = 16'h0001; bus.din_valid = 1'b1;
    tick();                               // cycle 2: gap
    bus.din_valid = 1'b0; bus.din = 16'hFFFF;
    check("misr_c2_done",   bus.done,          32'h0);
    check("misr_c2_busy",   bus.busy,          32'h1);
    tick();                               // cycle 3
    check("misr_c3_done",   bus.done,          32'h0);
    bus.din = 16'h0003; bus.din_valid = 1'b1;
    tick();                               // cycle 4
    bus.din_valid = 1'b0;
    check("misr_c4_done",   bus.done,          32'h1);
    check("misr_signature", bus.signature,     32'h8003);
    check("misr_c4_pvalid", bus.pattern_valid, 32'h0);
    tick();

    // ---- GEN N = 10 from ACE1, abort in cycle 4.
    // ACE1 -> 5670 -> AB38 -> 559C (taps 0,2,3,5).
    bus.seed_load = 1'b1; bus.seed = 16'hACE1;
    bus.start = 1'b1; bus.mode = 1'b0; bus.num_patterns = 16'd10;
    tick();                               // cycle 1
    bus.seed_load = 1'b0; bus.start = 1'b0;
    check("abort_c1_pattern", bus.pattern, 32'hACE1);
    tick();                               // cycle 2
    check("abort_c2_pattern", bus.pattern, 32'h5670);
    // seed_load/start outside IDLE must be ignored
    bus.seed_load = 1'b1; bus.seed = 16'h0000; bus.start = 1'b1;
    tick();                               // cycle 3
    bus.seed_load = 1'b0; bus.start = 1'b0;
    check("abort_c3_pattern", bus.pattern, 32'hAB38);
    tick();                               // cycle 4
    check("abort_c4_pattern", bus.pattern, 32'h559C);
    bus.abort = 1'b1;
    tick();                               // cycle 5
    bus.abort = 1'b0;
    check("abort_c5_busy",   bus.busy,          32'h0);
    check("abort_c5_pvalid", bus.pattern_valid, 32'h0);
    check("abort_c5_done",   bus.done,          32'h0);
    check("abort_sig_kept",  bus.signature,     32'h8003);
    tick();                               // cycle 6
    check("abort_c6_done",   bus.done,          32'h0);
    // state was frozen at 559C, so the next run starts there
    bus.start = 1'b1; bus.mode = 1'b0; bus.num_patterns = 16'd1;
    tick();
    bus.start = 1'b0;
    check("abort_state_kept", bus.pattern, 32'h559C);
    tick();
    check("abort_rerun_done", bus.done,    32'h1);
    tick();

    // ---- GEN N = 10, reset in cycle 4
    bus.start = 1'b1; bus.mode = 1'b0; bus.num_patterns = 16'd10;
    tick();                               // cycle 1
    bus.start = 1'b0;
    check("rstrun_c1_busy", bus.busy, 32'h1);
    tick();                               // cycle 2
    tick();                               // cycle 3
    tick();                               // cycle 4
    rst_n = 1'b0;
    #1;
    check("rstrun_pattern",   bus.pattern,       32'h0);
    check("rstrun_pvalid",    bus.pattern_valid, 32'h0);
    check("rstrun_busy",      bus.busy,          32'h0);
    check("rstrun_done",      bus.done,          32'h0);
    check("rstrun_signature", bus.signature,     32'h0);
    tick();
    check("rstrun_held_done", bus.done,          32'h0);
    rst_n = 1'b1;
    tick();
    // state is back at SEED
    bus.start = 1'b1; bus.mode = 1'b0; bus.num_patterns = 16'd1;
    tick();
    bus.start = 1'b0;
    check("rstrun_seed", bus.pattern, 32'hFFFF);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
